// File: rtl/param_arbiter.sv
// param_arbiter: registered N-way arbiter offering fixed-priority, round-robin and LFSR-random schemes.
// Define ARB_LOCK_EN to enable grant locking with a MAX_HOLD limit; otherwise the lock port is ignored.
module param_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [2:0]                 arb_type,
    input  logic [$clog2(NUM_REQ)-1:0] prio_sel,
    input  logic                       lock,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       gnt_valid
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [2:0] ARB_FIXED = 3'd0;
    localparam logic [2:0] ARB_RR    = 3'd1;
    localparam logic [2:0] ARB_RAND  = 3'd2;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]     last_id_q, last_id_d;
    logic [7:0]         lfsr_q, lfsr_d;

    logic               reserved;
    logic               top_ok;
    int                 top_idx;
    int                 rank;
    int                 best_rank;
    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic               hold_ok;

    assign reserved = (arb_type > ARB_RAND);
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Index given absolute top priority by the fixed and random schemes.
    always_comb begin
        top_ok  = 1'b0;
        top_idx = 0;
        case (arb_type)
            ARB_FIXED: begin
                top_ok  = (int'(prio_sel) < NUM_REQ);
                top_idx = int'(prio_sel);
            end
            ARB_RAND: begin
                top_ok  = 1'b1;
                top_idx = int'(lfsr_q) % NUM_REQ;
            end
            default: ;
        endcase
    end

    // Every scheme reduces to "lowest rank among requesters wins".
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rank      = 0;
        best_rank = NUM_REQ + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_type == ARB_RR)
                rank = (i + 2 * NUM_REQ - int'(last_id_q) - 1) % NUM_REQ;
            else
                rank = (top_ok && (i == top_idx)) ? 0 : i + 1;
            if (req[i] && !reserved && (rank < best_rank)) begin
                best_rank = rank;
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end

`ifdef ARB_LOCK_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    assign hold_ok = lock && gnt_valid_q && ((req & gnt_q) != '0) && !reserved
                     && (int'(hold_cnt_q) < MAX_HOLD);
    assign hold_cnt_d = hold_ok ? hold_cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt_q <= 8'd0;
        else
            hold_cnt_q <= hold_cnt_d;
    end
`else
    logic unused_lock;

    assign hold_ok     = 1'b0;
    assign unused_lock = lock;
`endif

    always_comb begin
        if (hold_ok) begin
            gnt_d       = gnt_q;
            gnt_id_d    = gnt_id_q;
            gnt_valid_d = 1'b1;
        end else begin
            gnt_valid_d = win_found;
            gnt_id_d    = win_found ? win_id : '0;
            gnt_d       = win_found ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_id) : '0;
        end
        last_id_d = gnt_valid_d ? gnt_id_d : last_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            last_id_q   <= IDW'(NUM_REQ - 1);
            lfsr_q      <= 8'h01;
        end else begin
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            last_id_q   <= last_id_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: doc/param_arbiter.md
PARAM_ARBITER -- requirements
Module: param_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 8, number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 16, maximum consecutive cycles a locked grant is held; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port req  input  NUM_REQ  request vector; bit i = requester i.
REQ-006 Port arb_type  input  3  scheme: 0 fixed priority, 1 round robin, 2 random, 3..7 reserved.
REQ-007 Port prio_sel  input  clog2(NUM_REQ)  top-priority index for fixed scheme.
REQ-008 Port lock  input  1  request to hold the current grant.
REQ-009 Port gnt  output  NUM_REQ  registered one-hot grant, or zero.
REQ-010 Port gnt_id  output  clog2(NUM_REQ)  binary index of gnt; 0 when gnt is zero.
REQ-011 Port gnt_valid  output  1  OR-reduction of gnt.

Function
REQ-012 gnt shall be registered: the value in cycle t+1 is computed from req, arb_type, prio_sel, lock and internal state sampled in cycle t (1-cycle latency).
REQ-013 gnt shall never have more than one bit set, and a bit shall be set only if the same bit of req was set in the sampling cycle.
REQ-014 If req is zero in the sampling cycle, the next gnt shall be zero, except as stated in REQ-019.
REQ-015 Fixed scheme: prio_sel index wins if requesting; otherwise the lowest requesting index wins. If prio_sel >= NUM_REQ, the lowest requesting index wins.
REQ-016 Round robin: search starts at (last_id+1) mod NUM_REQ and ascends with wrap-around; the first requesting index wins.
REQ-017 last_id shall update to gnt_id on every cycle that gnt is non-zero, in any scheme; it shall hold otherwise.
REQ-018 Random scheme: an internal 8-bit maximal Fibonacci LFSR (taps 8,6,5,4) shall advance every cycle. Index lfsr % NUM_REQ is top priority; the remaining indices follow in ascending order as in REQ-015.
REQ-019 Reserved arb_type values shall produce gnt zero and shall release any lock.
REQ-020 Lock (ARB_LOCK_EN only): if lock=1, gnt is non-zero, the granted bit of req is still 1 and hold_cnt < MAX_HOLD, the grant shall be repeated unchanged regardless of scheme or other requests.
REQ-021 hold_cnt shall increment on each repeated (locked) grant and reset to 0 on any new arbitration. When hold_cnt reaches MAX_HOLD, normal arbitration shall run for the next grant.
REQ-022 In the MAX_HOLD case with round robin, the holder has lowest priority per REQ-016. In the fixed and random schemes the holder may win again, and hold_cnt restarts at 0.
REQ-023 A change of arb_type in mid-lock shall not break a valid lock; the new scheme applies at the first non-locked arbitration.

Reset
REQ-024 While rst_n=0: gnt=0, gnt_id=0, gnt_valid=0, last_id=NUM_REQ-1, hold_cnt=0, lfsr=8'h01.
REQ-025 Assertion of rst_n mid-lock shall clear all state immediately. The first post-reset round-robin grant goes to the lowest requesting index.

Configuration
REQ-026 Macro ARB_LOCK_EN defined: lock, hold_cnt and MAX_HOLD behave as in REQ-020..REQ-023.
REQ-027 Macro ARB_LOCK_EN undefined: the lock port is present but ignored, no hold counter is synthesised, and every cycle is a fresh arbitration.

Verification
REQ-028 NUM_REQ=8, arb_type=0, prio_sel=5, req=8'b0010_0110 -> next cycle gnt=8'b0010_0000, gnt_id=5. Then req=8'b0000_0110 -> gnt=8'b0000_0010.
REQ-029 arb_type=1, req=8'hFF held for 9 cycles after reset -> gnt_id sequence 0,1,2,3,4,5,6,7,0.
REQ-030 arb_type=1, last_id=6, req=8'b0100_0001 -> gnt_id=0. Next cycle -> gnt_id=6 (wrap-around).
REQ-031 ARB_LOCK_EN, MAX_HOLD=3, arb_type=1, req=8'h03, lock=1 from first grant of 0 -> gnt_id 0,0,0,0,1 (one grant plus 3 holds, then rotation).
REQ-032 arb_type=2, req=8'hFF for 255 cycles -> every grant one-hot, all 8 indices granted at least once. Then arb_type=5 -> gnt=0 next cycle.
REQ-033 Locked grant active, rst_n pulsed low for one cycle -> gnt=0 immediately. After release, arb_type=1, req=8'h80 -> gnt_id=7 one cycle later.
